// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and glyph constants for the 4-digit BCD 7-segment scanner.
// Glyphs are active-high and ordered {g,f,e,d,c,b,a}.
// Contents:
//   seg7_t      - 7-bit glyph type
//   phase_t     - per-slot phase of the scan FSM (blank gap / drive)
//   SEG7_DIGIT  - glyphs for decimal digits 0..9
//   SEG7_DASH   - glyph for an invalid BCD nibble (segment g only)
//   SEG7_BLANK  - all segments off
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    localparam seg7_t SEG7_DIGIT [0:9] = '{
        7'h3F,
        7'h06,
        7'h5B,
        7'h4F,
        7'h66,
        7'h6D,
        7'h7D,
        7'h07,
        7'h7F,
        7'h6F
    };

    localparam seg7_t SEG7_DASH  = 7'h40;
    localparam seg7_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/bcd_digit_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_digit_to_seg7
// Combinational decoder from one BCD nibble to an active-high 7-segment glyph.
// Nibbles 10..15 are not valid BCD and are shown as a dash so that a corrupted
// upstream value is visible on the display instead of a misleading digit.
// Ports:
//   nibble - 4-bit BCD digit
//   glyph  - active-high {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_digit_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      glyph
);

    always_comb begin
        glyph = SEG7_DASH;
        case (nibble)
            4'd0: glyph = SEG7_DIGIT[0];
            4'd1: glyph = SEG7_DIGIT[1];
            4'd2: glyph = SEG7_DIGIT[2];
            4'd3: glyph = SEG7_DIGIT[3];
            4'd4: glyph = SEG7_DIGIT[4];
            4'd5: glyph = SEG7_DIGIT[5];
            4'd6: glyph = SEG7_DIGIT[6];
            4'd7: glyph = SEG7_DIGIT[7];
            4'd8: glyph = SEG7_DIGIT[8];
            4'd9: glyph = SEG7_DIGIT[9];
            default: glyph = SEG7_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg7_scan
// Time-multiplexed driver for a 4-digit common-anode 7-segment display fed
// with a packed BCD word {thousands,hundreds,tens,ones}. Each digit owns a
// slot of SCAN_DIV clocks; the first BLANK_CYC clocks of every slot keep all
// digits dark to suppress ghosting. The input is double-buffered: a strobed
// value waits in 'held' and only moves to the displayed 'shadow' copy at a
// frame boundary, so a frame never mixes two values.
//
// Parameters:
//   SCAN_DIV   - clocks per digit slot (>= 2)
//   BLANK_CYC  - dark clocks at the start of each slot (0 <= BLANK_CYC < SCAN_DIV)
//   ACTIVE_LOW - 1: seg/dig pins asserted low, 0: asserted high
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   bcd        - packed BCD, [3:0] ones .. [15:12] thousands
//   bcd_valid  - one-cycle load strobe for bcd
//   seg        - {dp,g,f,e,d,c,b,a}, registered
//   dig        - digit enables, dig[0] = ones digit, registered
//   frame_done - one-cycle pulse after digit 3's slot ends
//
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits (3..1) are shown
//                           dark; digit 0 always shows.
// -----------------------------------------------------------------------------
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 12500,
    parameter int BLANK_CYC  = 250,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        bcd_valid,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_done
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
    localparam logic [7:0]    SEG_POL   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0]    DIG_POL   = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam phase_t        PHASE_RST = (BLANK_CYC > 0) ? PH_BLANK : PH_DRIVE;

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    phase_t        phase;
    phase_t        phase_nxt;
    logic          slot_end;
    logic          frame_end;

    logic [15:0]   held;
    logic [15:0]   shadow;
    logic          pending;

    logic [3:0]    nibble;
    seg7_t         glyph;
    logic          lz_blank;
    logic [7:0]    seg_nxt;
    logic [3:0]    dig_nxt;

    // Scan state register: slot counter, digit index and the phase of the
    // current slot. phase is kept in step with slot_cnt so the output stage
    // only has to look at registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
            phase    <= PHASE_RST;
        end else begin
            slot_cnt <= slot_nxt;
            idx      <= idx_nxt;
            phase    <= phase_nxt;
        end
    end

    // Next-state logic. The phase of the next slot position is derived from
    // the next counter value; with BLANK_CYC = 0 the block never blanks.
    always_comb begin
        slot_end  = (slot_cnt == SLOT_LAST);
        frame_end = slot_end && (idx == 2'd3);
        slot_nxt  = slot_end ? '0 : slot_cnt + CW'(1);
        idx_nxt   = slot_end ? idx + 2'd1 : idx;
        phase_nxt = PH_DRIVE;
        if ((BLANK_CYC > 0) && (slot_nxt < BLANK_LIM)) begin
            phase_nxt = PH_BLANK;
        end
    end

    // Double buffer. A strobe always refreshes 'held'; the displayed copy only
    // changes at the frame boundary. A strobe landing exactly on the boundary
    // goes straight to the display and leaves nothing pending behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held    <= 16'h0000;
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (bcd_valid) begin
                held <= bcd;
            end
            if (frame_end && bcd_valid) begin
                shadow  <= bcd;
                pending <= 1'b0;
            end else if (frame_end && pending) begin
                shadow  <= held;
                pending <= 1'b0;
            end else if (bcd_valid) begin
                pending <= 1'b1;
            end
        end
    end

    // Select the nibble belonging to the digit currently being scanned.
    always_comb begin
        nibble = shadow[3:0];
        case (idx)
            2'd0: nibble = shadow[3:0];
            2'd1: nibble = shadow[7:4];
            2'd2: nibble = shadow[11:8];
            2'd3: nibble = shadow[15:12];
            default: nibble = shadow[3:0];
        endcase
    end

    bcd_digit_to_seg7 u_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

    // Leading-zero suppression: a digit goes dark when it and every more
    // significant nibble are zero. The ones digit is never suppressed.
    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            2'd3: lz_blank = (shadow[15:12] == 4'h0);
            2'd2: lz_blank = (shadow[15:8] == 8'h00);
            2'd1: lz_blank = (shadow[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    // Active-high output decode for the current phase. During the blank gap
    // everything is off; during drive exactly one enable is set. dp stays off.
    always_comb begin
        seg_nxt = 8'h00;
        dig_nxt = 4'h0;
        if (phase == PH_DRIVE) begin
            dig_nxt = 4'b0001 << idx;
            seg_nxt = lz_blank ? {1'b0, SEG7_BLANK} : {1'b0, glyph};
        end
    end

    // Output register. Polarity is applied here so the pins are glitch-free
    // and the reset value is "all off" in either polarity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= SEG_POL;
            dig        <= DIG_POL;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt ^ SEG_POL;
            dig        <= dig_nxt ^ DIG_POL;
            frame_done <= frame_end;
        end
    end

endmodule

// File: doc/bcd_seg7_scan.md
Name: bcd_seg7_scan

Overview:
- Downstream consumer of the 16-bit packed BCD word {thousands,hundreds,tens,ones} from the binary-to-BCD converter.
- Drives a 4-digit multiplexed common-anode 7-segment display on the Cyclone IV board.
- Time-multiplexes the digits with a prescaled scan counter and inserts a ghost-suppression blanking gap per digit.
- Double-buffers the input so a display frame never tears mid-scan.

Parameters:
SCAN_DIV, 12500, clock cycles per digit slot (50 MHz -> 4 kHz slot, 1 kHz frame); legal range >= 2
BLANK_CYC, 250, cycles at the start of each slot with all digits off; legal range 0 <= BLANK_CYC < SCAN_DIV
ACTIVE_LOW, 1, 1 = seg and dig are asserted low; 0 = asserted high

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
bcd  input  16  packed BCD; [3:0] ones ... [15:12] thousands
bcd_valid  input  1  one-cycle load strobe for bcd
seg  output  8  {dp,g,f,e,d,c,b,a}
dig  output  4  digit enables; dig[0] = ones digit
frame_done  output  1  one-cycle pulse when digit 3's slot ends

Behaviour:
- Interface: one clock, clk. rst_n is a synchronous, active-low reset.
- Reset (rst_n=0 at a clk edge):
  - slot_cnt=0, idx=0, held=0, shadow=0, pending=0.
  - seg=all off (8'hFF when ACTIVE_LOW), dig=all off (4'hF when ACTIVE_LOW), frame_done=0.
  - Reset mid-frame aborts the scan immediately; no pending value survives.
- Input capture:
  - bcd_valid=1 -> held<=bcd, pending<=1.
  - Last strobe before a frame boundary wins.
- Scan counter:
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - At slot_cnt==SCAN_DIV-1, idx advances 0->1->2->3->0.
- Frame boundary (slot_cnt==SCAN_DIV-1 and idx==3):
  - frame_done=1 in the following cycle.
  - If pending: shadow<=held and pending<=0.
  - If bcd_valid coincides with the boundary, shadow<=bcd directly and pending stays 0.
- Phase FSM per slot:
  - BLANK while slot_cnt < BLANK_CYC; DRIVE otherwise.
  - BLANK_CYC=0 means the block is always in DRIVE.
- Outputs:
  - BLANK: dig all off, seg all off.
  - DRIVE: only dig[idx] active; seg = decode(shadow[4*idx+3 -: 4]).
  - seg and dig are registered: 1-cycle latency from counter state to pins.
- Decode:
  - 0-9 -> standard glyphs.
  - Nibble 10-15 (invalid BCD) -> dash: segment g only.
  - dp is always off.
- Polarity:
  - Decode and enable logic are active-high internally.
  - When ACTIVE_LOW=1, seg and dig are inverted at the output register.
- Never more than one dig asserted in any cycle, including across reset release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3,2,1) shows blank segments when its nibble and all higher nibbles are 0.
  - Digit 0 always shows.
  - dig timing is unchanged.
  - Example: shadow=16'h0042 shows " 42"; digits 3 and 2 are dark.
- Undefined: all four digits are always decoded; 16'h0042 shows "0042".

Decomposition:
- Package seg7_pkg:
  - seg7_t (7-bit glyph typedef).
  - Constants SEG7_DIGIT[0:9], SEG7_DASH, SEG7_BLANK (active-high).
- Sub-module bcd_digit_to_seg7:
  - Combinational 4-bit nibble -> seg7_t decoder, including the invalid-nibble dash.
  - Instantiated once, fed by the idx-selected nibble.
- Scan counter, phase FSM, buffering and optional blanking stay in bcd_seg7_scan.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1):
1. Reset: hold rst_n=0 3 cycles -> seg=8'hFF, dig=4'hF, frame_done=0; after release, dig=4'hF for the first 3 cycles (blank + latency), then dig=4'b1110.
2. Scan order: bcd=16'h1234 strobed, wait 1 frame -> dig sequence 1110/1101/1011/0111 with seg low bits = ~glyph 4,3,2,1; each digit active 6 cycles; all-off gap of 2 cycles between digits; frame_done every 32 cycles.
3. Tear-free update: strobe 16'h5678 while idx=1 -> digits 2 and 3 still show 2,1; new value appears from the next frame's digit 0; strobes 16'h1111 then 16'h2222 in the same frame -> 2222 displayed.
4. Boundary coincidence: bcd_valid with 16'h9999 on the exact frame-boundary cycle -> next frame shows 9999; pending=0 afterwards.
5. Invalid BCD: bcd=16'hA0F3 -> digits 3 and 1 show dash (seg=8'b1011_1111); digit 2 shows 0; digit 0 shows 3.
6. With LEADING_ZERO_BLANK_EN: bcd=16'h0000 -> only digit 0 lit, showing "0"; bcd=16'h0105 -> digit 3 blank, digits 2..0 show "105".
